// File: rtl/stream_settings_bank_if.sv
// Host-side set/get strobe bus feeding the settings bank.
interface stream_settings_bank_if #(
    parameter int C_DATAWIDTH = 32,
    parameter int C_ADDRWIDTH = 32
);
    logic [C_DATAWIDTH-1:0] set_data;
    logic                   set_stb;
    logic [C_ADDRWIDTH-1:0] set_addr;
    logic                   get_stb;
    logic [C_ADDRWIDTH-1:0] get_addr;
    logic [C_DATAWIDTH-1:0] get_data;
    logic                   get_ack;

    modport master (
        output set_data, set_stb, set_addr, get_stb, get_addr,
        input  get_data, get_ack
    );

    modport slave (
        input  set_data, set_stb, set_addr, get_stb, get_addr,
        output get_data, get_ack
    );
endinterface

// File: rtl/stream_settings_bank.sv
// Per-channel AXI user/cache settings bank with soft reset, lock and sticky status.
// Optional SETTINGS_SHADOW_EN: channel writes land in shadows, a commit copies them out.
module stream_settings_bank #(
    parameter int C_DATAWIDTH    = 32,
    parameter int C_ADDRWIDTH    = 32,
    parameter int C_PAGEWIDTH    = 12,
    parameter int C_NUM_CHANNELS = 4,
    parameter int C_RESET_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    stream_settings_bank_if.slave       bus,
    input  logic [C_NUM_CHANNELS-1:0]   status_in,
    output logic                        soft_reset,
    output logic [5*C_NUM_CHANNELS-1:0] aruser,
    output logic [4*C_NUM_CHANNELS-1:0] arcache,
    output logic [5*C_NUM_CHANNELS-1:0] awuser,
    output logic [4*C_NUM_CHANNELS-1:0] awcache
);
    localparam int IW = C_PAGEWIDTH - 2;
    localparam int CW = (C_NUM_CHANNELS > 1) ? $clog2(C_NUM_CHANNELS) : 1;
    localparam logic [7:0] RC   = 8'(C_RESET_CYCLES);
    localparam logic [7:0] NCH8 = 8'(C_NUM_CHANNELS);
    localparam logic [IW-1:0] CH_BASE = IW'(8);
    localparam logic [IW-1:0] CH_END  = IW'(8 + 4 * C_NUM_CHANNELS);

    // ---------------- address decode ----------------
    logic [IW-1:0] w_set_idx, w_get_idx, w_set_off, w_get_off;
    logic          w_set_isch, w_get_isch;
    logic [CW-1:0] w_set_ch, w_get_ch;
    logic [1:0]    w_set_fld, w_get_fld;

    assign w_set_idx  = bus.set_addr[C_PAGEWIDTH-1:2];
    assign w_get_idx  = bus.get_addr[C_PAGEWIDTH-1:2];
    assign w_set_isch = (w_set_idx >= CH_BASE) && (w_set_idx < CH_END);
    assign w_get_isch = (w_get_idx >= CH_BASE) && (w_get_idx < CH_END);
    assign w_set_off  = w_set_idx - CH_BASE;
    assign w_get_off  = w_get_idx - CH_BASE;
    assign w_set_ch   = w_set_off[CW+1:2];
    assign w_get_ch   = w_get_off[CW+1:2];
    assign w_set_fld  = w_set_off[1:0];
    assign w_get_fld  = w_get_off[1:0];

    // ---------------- control registers ----------------
    logic                      r_lock;
    logic [C_NUM_CHANNELS-1:0] r_status;
    logic [7:0]                r_cnt;
    logic                      w_srst, w_chwr, w_commit;
    logic [C_NUM_CHANNELS-1:0] w_clr;

    // Soft reset restores channel state on the same edge the trigger is taken,
    // so defaults are already visible in the first cycle of the pulse.
    assign w_srst   = bus.set_stb && (w_set_idx == IW'(0));
    assign w_chwr   = bus.set_stb && w_set_isch && !r_lock;
`ifdef SETTINGS_SHADOW_EN
    assign w_commit = bus.set_stb && (w_set_idx == IW'(4)) && !r_lock;
`else
    assign w_commit = 1'b0;
`endif
    assign w_clr    = (bus.set_stb && (w_set_idx == IW'(3))) ?
                      bus.set_data[C_NUM_CHANNELS-1:0] : '0;
    assign soft_reset = (r_cnt != 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock   <= 1'b0;
            r_status <= '0;
            r_cnt    <= 8'd0;
        end else begin
            // New events win over a same-cycle clear.
            r_status <= (r_status & ~w_clr) | status_in;
            if (w_srst)
                r_cnt <= RC;
            else if (r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
            if (w_srst)
                r_lock <= 1'b0;
            else if (bus.set_stb && (w_set_idx == IW'(2)))
                r_lock <= bus.set_data[0];
        end
    end

    // ---------------- per-channel registers ----------------
    logic [4:0] w_rv_aru [C_NUM_CHANNELS];
    logic [3:0] w_rv_arc [C_NUM_CHANNELS];
    logic [4:0] w_rv_awu [C_NUM_CHANNELS];
    logic [3:0] w_rv_awc [C_NUM_CHANNELS];

    for (genvar c = 0; c < C_NUM_CHANNELS; c++) begin : g_ch
        logic       w_hit;
        logic [4:0] r_aru, r_awu;
        logic [3:0] r_arc, r_awc;

        assign w_hit = w_chwr && (w_set_ch == CW'(c));

        // r_* is the write target: the output itself, or the shadow when enabled.
        always_ff @(posedge clk) begin
            if (rst || w_srst) begin
                r_aru <= 5'h1f;
                r_arc <= 4'hf;
                r_awu <= 5'h1f;
                r_awc <= 4'hf;
            end else if (w_hit) begin
                case (w_set_fld)
                    2'd0: r_aru <= bus.set_data[4:0];
                    2'd1: r_arc <= bus.set_data[3:0];
                    2'd2: r_awu <= bus.set_data[4:0];
                    default: r_awc <= bus.set_data[3:0];
                endcase
            end
        end

        assign w_rv_aru[c] = r_aru;
        assign w_rv_arc[c] = r_arc;
        assign w_rv_awu[c] = r_awu;
        assign w_rv_awc[c] = r_awc;

`ifdef SETTINGS_SHADOW_EN
        logic [4:0] r_o_aru, r_o_awu;
        logic [3:0] r_o_arc, r_o_awc;

        always_ff @(posedge clk) begin
            if (rst || w_srst) begin
                r_o_aru <= 5'h1f;
                r_o_arc <= 4'hf;
                r_o_awu <= 5'h1f;
                r_o_awc <= 4'hf;
            end else if (w_commit) begin
                r_o_aru <= r_aru;
                r_o_arc <= r_arc;
                r_o_awu <= r_awu;
                r_o_awc <= r_awc;
            end
        end

        assign aruser [5*c +: 5] = r_o_aru;
        assign arcache[4*c +: 4] = r_o_arc;
        assign awuser [5*c +: 5] = r_o_awu;
        assign awcache[4*c +: 4] = r_o_awc;
`else
        assign aruser [5*c +: 5] = r_aru;
        assign arcache[4*c +: 4] = r_arc;
        assign awuser [5*c +: 5] = r_awu;
        assign awcache[4*c +: 4] = r_awc;
`endif
    end

    // ---------------- read path ----------------
    logic [31:0]            w_rd32;
    logic [C_DATAWIDTH-1:0] r_get_data;
    logic                   r_get_ack;

    always_comb begin
        w_rd32 = 32'h01234567;
        if (w_get_isch) begin
            case (w_get_fld)
                2'd0: w_rd32 = {27'd0, w_rv_aru[w_get_ch]};
                2'd1: w_rd32 = {28'd0, w_rv_arc[w_get_ch]};
                2'd2: w_rd32 = {27'd0, w_rv_awu[w_get_ch]};
                default: w_rd32 = {28'd0, w_rv_awc[w_get_ch]};
            endcase
        end else begin
            case (w_get_idx)
                IW'(0): w_rd32 = 32'hace0ba54;
                IW'(1): w_rd32 = {16'h0002, 8'h00, NCH8};
                IW'(2): w_rd32 = {31'd0, r_lock};
                IW'(3): w_rd32 = 32'(r_status);
`ifdef SETTINGS_SHADOW_EN
                IW'(4): w_rd32 = 32'd0;
`endif
                default: w_rd32 = 32'h01234567;
            endcase
        end
    end

    // Sampled before this edge's writes land, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_get_data <= '0;
            r_get_ack  <= 1'b0;
        end else begin
            r_get_ack <= bus.get_stb;
            if (bus.get_stb)
                r_get_data <= C_DATAWIDTH'(w_rd32);
        end
    end

    assign bus.get_data = r_get_data;
    assign bus.get_ack  = r_get_ack;

    logic w_unused;
    assign w_unused = ^{bus.set_data, bus.set_addr, bus.get_addr, w_commit};
endmodule
